// File: rtl/parser_rule_loader_if.sv
// Host/parser-facing bundle of the rule loader: table load port, run control,
// status, and the parser rule write/read-back bus.
interface parser_rule_loader_if #(
    parameter int ENTRY_NUM = 64,
    parameter int CNT_W     = $clog2(ENTRY_NUM + 1)
);
    logic             i_tbl_wren;
    logic [CNT_W-1:0] i_tbl_addr;
    logic [63:0]      i_tbl_wdata;
    logic [CNT_W-1:0] i_entry_num;
    logic             i_start;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [1:0]       o_err_code;
    logic [CNT_W-1:0] o_err_idx;
    logic             o_rule_wren;
    logic             o_rule_rden;
    logic [31:0]      o_rule_addr;
    logic [31:0]      o_rule_wdata;
    logic             i_rule_rdata_valid;
    logic [31:0]      i_rule_rdata;

    modport slave (
        input  i_tbl_wren, i_tbl_addr, i_tbl_wdata, i_entry_num, i_start,
               i_rule_rdata_valid, i_rule_rdata,
        output o_busy, o_done, o_err, o_err_code, o_err_idx,
               o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata
    );

    modport master (
        output i_tbl_wren, i_tbl_addr, i_tbl_wdata, i_entry_num, i_start,
               i_rule_rdata_valid, i_rule_rdata,
        input  o_busy, o_done, o_err, o_err_code, o_err_idx,
               o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata
    );
endinterface

// File: rtl/parser_rule_loader.sv
// Rule-configuration sequencer: replays a host-loaded table of {address, data}
// writes onto the parser rule port, with optional per-entry read-back check.
module parser_rule_loader #(
    parameter int ENTRY_NUM  = 64,
    parameter bit VERIFY     = 1'b1,
    parameter int RD_TIMEOUT = 15,
    parameter int CNT_W      = $clog2(ENTRY_NUM + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    parser_rule_loader_if.slave rule_if
);
    localparam int               AW           = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam int               TW           = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ENTRY_MAX    = CNT_W'(ENTRY_NUM);
    localparam logic [TW-1:0]    TMO_LAST     = TW'(RD_TIMEOUT - 1);
    localparam logic [1:0]       ERR_MISMATCH = 2'b01;
    localparam logic [1:0]       ERR_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_RDREQ,
        S_RDWAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] err_idx_q, err_idx_d;
    logic             wren_q, wren_d;
    logic             rden_q, rden_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [63:0]      ent_q;

    logic [63:0]      tbl_mem [ENTRY_NUM];

    logic             start_ok;
    logic             tbl_we;
    logic             rd_match;
    logic             last_entry;
    logic             mis_hit;
    logic             tmo_hit;
    logic [CNT_W-1:0] num_clamped;

    assign start_ok    = rule_if.i_start && (state_q == S_IDLE);
    assign num_clamped = (rule_if.i_entry_num > ENTRY_MAX) ? ENTRY_MAX : rule_if.i_entry_num;
    assign rd_match    = (rule_if.i_rule_rdata == ent_q[31:0]);
    assign last_entry  = (idx_q + CNT_W'(1)) >= cnt_q;
    assign tbl_we      = rule_if.i_tbl_wren && !busy_q && (rule_if.i_tbl_addr < ENTRY_MAX);

    // Host table port; the table holds no reset so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (tbl_we) begin
            tbl_mem[rule_if.i_tbl_addr[AW-1:0]] <= rule_if.i_tbl_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mis_hit = 1'b0;
        tmo_hit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (num_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_WRITE;
            // Address bit 31 lets the host skip read-back for write-only rules.
            S_WRITE: state_d = (VERIFY && !ent_q[63]) ? S_RDREQ : S_NEXT;
            S_RDREQ: state_d = S_RDWAIT;
            S_RDWAIT: begin
                if (rule_if.i_rule_rdata_valid) begin
                    if (rd_match) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_DONE;
                        mis_hit = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_DONE;
                    tmo_hit = 1'b1;
                end
            end
            S_NEXT:  state_d = last_entry ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so they are glitch-free.
    always_comb begin
        wren_d = (state_d == S_WRITE);
        rden_d = (state_d == S_RDREQ);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wren_q <= 1'b0;
            rden_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            wren_q <= wren_d;
            rden_q <= rden_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        tmo_d      = '0;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
        if (start_ok) begin
            idx_d      = '0;
            cnt_d      = num_clamped;
            err_d      = 1'b0;
            err_code_d = 2'b00;
            err_idx_d  = '0;
        end
        if (state_q == S_NEXT) begin
            idx_d = idx_q + CNT_W'(1);
        end
        if (state_q == S_RDWAIT) begin
            tmo_d = tmo_q + TW'(1);
        end
        if (mis_hit || tmo_hit) begin
            err_d      = 1'b1;
            err_code_d = mis_hit ? ERR_MISMATCH : ERR_TIMEOUT;
            err_idx_d  = idx_q;
        end
    end

    // ent_q doubles as the rule address/data output register, held between strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            err_idx_q  <= '0;
            ent_q      <= '0;
        end else begin
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
            if (state_q == S_FETCH) begin
                ent_q <= tbl_mem[idx_q[AW-1:0]];
            end
        end
    end

    assign rule_if.o_busy       = busy_q;
    assign rule_if.o_done       = done_q;
    assign rule_if.o_err        = err_q;
    assign rule_if.o_err_code   = err_code_q;
    assign rule_if.o_err_idx    = err_idx_q;
    assign rule_if.o_rule_wren  = wren_q;
    assign rule_if.o_rule_rden  = rden_q;
    assign rule_if.o_rule_addr  = {1'b0, ent_q[62:32]};
    assign rule_if.o_rule_wdata = ent_q[31:0];

endmodule

// File: tb/tb_parser_rule_loader.sv
// Bench for parser_rule_loader: a VERIFY=0 and a VERIFY=1 instance share stimulus
// and are each checked against a per-entry cycle-cost model of the replay.
`timescale 1ns/1ps
module tb_parser_rule_loader;
    localparam int EN  = 64;
    localparam int CW  = $clog2(EN + 1);
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          tbl_wren = 1'b0;
    logic [CW-1:0] tbl_addr = '0;
    logic [63:0]   tbl_wdata = '0;
    logic [CW-1:0] entry_num = '0;
    logic          start = 1'b0;
    logic          rv;
    logic [31:0]   rdat;

    parser_rule_loader_if #(.ENTRY_NUM(EN), .CNT_W(CW)) if0 ();
    parser_rule_loader_if #(.ENTRY_NUM(EN), .CNT_W(CW)) if1 ();

    assign if0.i_tbl_wren = tbl_wren;   assign if1.i_tbl_wren = tbl_wren;
    assign if0.i_tbl_addr = tbl_addr;   assign if1.i_tbl_addr = tbl_addr;
    assign if0.i_tbl_wdata = tbl_wdata; assign if1.i_tbl_wdata = tbl_wdata;
    assign if0.i_entry_num = entry_num; assign if1.i_entry_num = entry_num;
    assign if0.i_start = start;         assign if1.i_start = start;
    assign if0.i_rule_rdata_valid = rv; assign if1.i_rule_rdata_valid = rv;
    assign if0.i_rule_rdata = rdat;     assign if1.i_rule_rdata = rdat;

    parser_rule_loader #(.ENTRY_NUM(EN), .VERIFY(1'b0), .RD_TIMEOUT(TMO), .CNT_W(CW)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .rule_if(if0.slave));
    parser_rule_loader #(.ENTRY_NUM(EN), .VERIFY(1'b1), .RD_TIMEOUT(TMO), .CNT_W(CW)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .rule_if(if1.slave));

    logic          wren [2], rden [2], done [2], busy [2], err [2];
    logic [1:0]    code [2];
    logic [CW-1:0] eidx [2];
    logic [31:0]   addr [2], wdat [2];
    assign wren[0] = if0.o_rule_wren;  assign wren[1] = if1.o_rule_wren;
    assign rden[0] = if0.o_rule_rden;  assign rden[1] = if1.o_rule_rden;
    assign done[0] = if0.o_done;       assign done[1] = if1.o_done;
    assign busy[0] = if0.o_busy;       assign busy[1] = if1.o_busy;
    assign err[0]  = if0.o_err;        assign err[1]  = if1.o_err;
    assign code[0] = if0.o_err_code;   assign code[1] = if1.o_err_code;
    assign eidx[0] = if0.o_err_idx;    assign eidx[1] = if1.o_err_idx;
    assign addr[0] = if0.o_rule_addr;  assign addr[1] = if1.o_rule_addr;
    assign wdat[0] = if0.o_rule_wdata; assign wdat[1] = if1.o_rule_wdata;

    // Reference table and per-entry responder plan (mode 0 echo, 1 corrupt, 2 silent).
    logic [63:0] ref_tbl [EN];
    int rsp_mode [EN];
    int rsp_d [EN];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Observed per-run activity, times relative to the accepted start cycle.
    int          m_start [2], m_wr_n [2], m_rd_n [2], m_dn_n [2], m_done_t [2], strobes [2];
    int          m_wr_t [2][128], m_rd_t [2][128];
    logic [31:0] m_wr_a [2][128], m_wr_d [2][128], m_rd_a [2][128];
    logic        m_err [2], m_busy_dn [2], m_busy_after [2];
    logic [1:0]  m_code [2];
    logic [CW-1:0] m_eidx [2];
    bit          m_prev_dn [2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_start[u] = 0; m_wr_n[u] = 0; m_rd_n[u] = 0; m_dn_n[u] = 0; strobes[u] = 0; m_prev_dn[u] = 0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (m_prev_dn[u]) begin
                    m_busy_after[u] = busy[u];
                    m_prev_dn[u] = 0;
                end
                if (start && !busy[u] && rst_n) begin
                    m_start[u] = cyc; m_wr_n[u] = 0; m_rd_n[u] = 0; m_dn_n[u] = 0;
                end
                if (wren[u]) begin
                    strobes[u]++;
                    if (m_wr_n[u] < 128) begin
                        m_wr_t[u][m_wr_n[u]] = cyc - m_start[u];
                        m_wr_a[u][m_wr_n[u]] = addr[u];
                        m_wr_d[u][m_wr_n[u]] = wdat[u];
                    end
                    m_wr_n[u]++;
                end
                if (rden[u]) begin
                    strobes[u]++;
                    if (m_rd_n[u] < 128) begin
                        m_rd_t[u][m_rd_n[u]] = cyc - m_start[u];
                        m_rd_a[u][m_rd_n[u]] = addr[u];
                    end
                    m_rd_n[u]++;
                end
                if (done[u]) begin
                    if (m_dn_n[u] == 0) begin
                        m_done_t[u] = cyc - m_start[u];
                        m_err[u] = err[u]; m_code[u] = code[u]; m_eidx[u] = eidx[u];
                        m_busy_dn[u] = busy[u];
                        m_prev_dn[u] = 1;
                    end
                    m_dn_n[u]++;
                end
            end
        end
    end

    // Parser read-back responder driven by the VERIFY=1 instance.
    initial begin
        int wi;
        int pend;
        logic [31:0] pdat;
        wi = 0; pend = -1; pdat = '0; rv = 1'b0; rdat = '0;
        forever begin
            @(negedge clk);
            rv = 1'b0;
            if (!busy[1]) begin
                wi = 0; pend = -1;
            end
            if (pend == 0) begin
                rv = 1'b1; rdat = pdat; pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
            if (wren[1]) wi++;
            if (rden[1] && wi > 0) begin
                if (rsp_mode[wi-1] == 0) begin
                    pend = rsp_d[wi-1]; pdat = wdat[1];
                end else if (rsp_mode[wi-1] == 1) begin
                    pend = rsp_d[wi-1]; pdat = wdat[1] ^ 32'h1;
                end
            end
        end
    end

    // Expected schedule: FETCH of entry 0 is 1 cycle after start; an entry costs
    // 3 cycles plain or 5+d when read back; DONE lands where the next FETCH would.
    int         e_wr_n [2], e_rd_n [2], e_done_t [2], e_eidx [2];
    int         e_wr_t [2][128], e_rd_t [2][128], e_wr_k [2][128], e_rd_k [2][128];
    bit         e_err [2];
    logic [1:0] e_code [2];

    task automatic model(input int u, input int req, input bit ver);
        int n;
        int t;
        n = (req > EN) ? EN : req;
        t = 1;
        e_wr_n[u] = 0; e_rd_n[u] = 0; e_err[u] = 0; e_code[u] = 2'b00; e_eidx[u] = 0;
        e_done_t[u] = 1;
        for (int k = 0; k < n; k++) begin
            e_wr_t[u][e_wr_n[u]] = t + 1; e_wr_k[u][e_wr_n[u]] = k; e_wr_n[u]++;
            if (ver && !ref_tbl[k][63]) begin
                e_rd_t[u][e_rd_n[u]] = t + 2; e_rd_k[u][e_rd_n[u]] = k; e_rd_n[u]++;
                if (rsp_mode[k] == 2) begin
                    e_done_t[u] = t + 3 + TMO; e_err[u] = 1; e_code[u] = 2'b10; e_eidx[u] = k;
                    return;
                end
                if (rsp_mode[k] == 1) begin
                    e_done_t[u] = t + 4 + rsp_d[k]; e_err[u] = 1; e_code[u] = 2'b01; e_eidx[u] = k;
                    return;
                end
                t += 5 + rsp_d[k];
            end else begin
                t += 3;
            end
        end
        e_done_t[u] = t;
    endtask

    task automatic verify_run(input int u, input string tag);
        int k;
        chk($sformatf("%s u%0d wr_count", tag, u), 64'(m_wr_n[u]), 64'(e_wr_n[u]));
        for (int i = 0; i < e_wr_n[u] && i < m_wr_n[u] && i < 128; i++) begin
            k = e_wr_k[u][i];
            chk($sformatf("%s u%0d wr%0d time", tag, u, i), 64'(m_wr_t[u][i]), 64'(e_wr_t[u][i]));
            chk($sformatf("%s u%0d wr%0d addr", tag, u, i), 64'(m_wr_a[u][i]), 64'({1'b0, ref_tbl[k][62:32]}));
            chk($sformatf("%s u%0d wr%0d data", tag, u, i), 64'(m_wr_d[u][i]), 64'(ref_tbl[k][31:0]));
        end
        chk($sformatf("%s u%0d rd_count", tag, u), 64'(m_rd_n[u]), 64'(e_rd_n[u]));
        for (int i = 0; i < e_rd_n[u] && i < m_rd_n[u] && i < 128; i++) begin
            k = e_rd_k[u][i];
            chk($sformatf("%s u%0d rd%0d time", tag, u, i), 64'(m_rd_t[u][i]), 64'(e_rd_t[u][i]));
            chk($sformatf("%s u%0d rd%0d addr", tag, u, i), 64'(m_rd_a[u][i]), 64'({1'b0, ref_tbl[k][62:32]}));
        end
        chk($sformatf("%s u%0d done_count", tag, u), 64'(m_dn_n[u]), 64'(1));
        if (m_dn_n[u] > 0) begin
            chk($sformatf("%s u%0d done_time", tag, u), 64'(m_done_t[u]), 64'(e_done_t[u]));
            chk($sformatf("%s u%0d err", tag, u), 64'(m_err[u]), 64'(e_err[u]));
            chk($sformatf("%s u%0d err_code", tag, u), 64'(m_code[u]), 64'(e_code[u]));
            chk($sformatf("%s u%0d err_idx", tag, u), 64'(m_eidx[u]), 64'(e_eidx[u]));
            chk($sformatf("%s u%0d busy_at_done", tag, u), 64'(m_busy_dn[u]), 64'(1));
            chk($sformatf("%s u%0d busy_after_done", tag, u), 64'(m_busy_after[u]), 64'(0));
        end
    endtask

    task automatic do_run(input string tag, input int req, input bit poke, input int poke_addr);
        int lim;
        model(0, req, 1'b0);
        model(1, req, 1'b1);
        lim = ((e_done_t[0] > e_done_t[1]) ? e_done_t[0] : e_done_t[1]) + 10;
        @(posedge clk); #2;
        entry_num = CW'(req); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        if (poke) begin
            repeat (2) @(posedge clk);
            #2;
            if (busy[0] && busy[1]) begin
                start = 1'b1; tbl_wren = 1'b1;
                tbl_addr = CW'(poke_addr); tbl_wdata = ~ref_tbl[poke_addr];
            end
            @(posedge clk); #2;
            start = 1'b0; tbl_wren = 1'b0;
        end
        for (int c = 0; c < lim; c++) begin
            if (m_dn_n[0] > 0 && m_dn_n[1] > 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #2;
        verify_run(0, tag);
        verify_run(1, tag);
    endtask

    task automatic load(input int k, input logic [63:0] v);
        ref_tbl[k] = v;
        @(posedge clk); #2;
        tbl_wren = 1'b1; tbl_addr = CW'(k); tbl_wdata = v;
        @(posedge clk); #2;
        tbl_wren = 1'b0;
    endtask

    function automatic logic [31:0] mk_addr(input bit nv, input int layer, input int cls, input int sub);
        return {nv, 15'h0, 4'(layer), 1'b0, 3'(cls), 8'(sub)};
    endfunction

    function automatic logic [63:0] rand_entry(input bit allow_nv);
        logic [31:0] a;
        a = mk_addr(allow_nv && ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 255)));
        return {a, 32'($urandom)};
    endfunction

    task automatic set_rsp(input int d);
        for (int k = 0; k < EN; k++) begin
            rsp_mode[k] = 0; rsp_d[k] = d;
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s u%0d strobes", tag, u), 64'({wren[u], rden[u], done[u], busy[u]}), 64'(0));
            chk($sformatf("%s u%0d status", tag, u), 64'({err[u], code[u], eidx[u]}), 64'(0));
            chk($sformatf("%s u%0d bus", tag, u), {addr[u], wdat[u]}, 64'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        for (int k = 0; k < EN; k++) ref_tbl[k] = '0;
        set_rsp(0);
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        rst_n = 1'b1;

        // Layer-0 ethernet: type offsets, packed key offsets, type rule, shifts.
        load(0, {mk_addr(0, 0, 2, 0), 32'd12});
        load(1, {mk_addr(0, 0, 2, 1), 32'd13});
        for (int j = 0; j < 4; j++)
            load(2 + j, {mk_addr(0, 0, 3, j), 7'h0, 1'((2*j+1) < 6), 8'(2*j+1), 7'h0, 1'((2*j) < 6), 8'(2*j)});
        load(6, {mk_addr(0, 0, 1, 0), 32'h0800_FFFF});
        load(7, {mk_addr(0, 0, 4, 0), 32'd7});
        load(8, {mk_addr(0, 0, 5, 0), 32'd6});
        set_rsp(1);
        do_run("eth", 9, 1'b0, 0);

        // Echo with d=2, plus busy-time start and table write to entry 0.
        for (int k = 0; k < 4; k++) load(k, rand_entry(1'b0));
        set_rsp(2);
        do_run("echo", 4, 1'b1, 0);

        load(1, {mk_addr(1, 2, 0, 1), 32'($urandom)});
        do_run("noverify_bit", 4, 1'b0, 0);

        for (int k = 0; k < 5; k++) load(k, rand_entry(1'b0));
        load(2, {mk_addr(0, 1, 3, 2), 32'h0000_0008});
        set_rsp(1);
        rsp_mode[2] = 1;
        do_run("mismatch", 5, 1'b0, 0);

        for (int k = 0; k < 3; k++) load(k, rand_entry(1'b0));
        set_rsp(0);
        rsp_mode[0] = 2;
        do_run("timeout", 3, 1'b0, 0);

        set_rsp(0);
        do_run("empty", 0, 1'b0, 0);

        for (int k = 0; k < EN; k++) load(k, rand_entry(1'b1));
        for (int k = 0; k < EN; k++) rsp_d[k] = int'($urandom_range(0, 2));
        do_run("clamp", EN + 5, 1'b1, int'($urandom_range(0, EN - 1)));

        for (int r = 0; r < 6; r++) begin
            int n;
            int m;
            n = int'($urandom_range(1, EN));
            for (int j = 0; j < 3; j++) load(int'($urandom_range(0, EN - 1)), rand_entry(1'b1));
            for (int k = 0; k < EN; k++) begin
                m = int'($urandom_range(0, 39));
                rsp_mode[k] = (m == 0) ? 2 : ((m < 3) ? 1 : 0);
                rsp_d[k] = int'($urandom_range(0, 4));
            end
            do_run($sformatf("rand%0d", r), n, 1'($urandom_range(0, 1)), int'($urandom_range(0, EN - 1)));
        end

        // Reset asserted while the plain instance is in WRITE.
        set_rsp(0);
        @(posedge clk); #2;
        entry_num = CW'(20); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (wren[0]) break;
            @(posedge clk); #2;
        end
        chk("midrun in_write", 64'(wren[0]), 64'(1));
        rst_n = 1'b0;
        #1;
        chk_zero("midrun_reset");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        s0 = strobes[0] + strobes[1];
        repeat (30) @(posedge clk);
        #2;
        chk("post_reset strobes", 64'(strobes[0] + strobes[1]), 64'(s0));
        chk("post_reset busy", 64'({busy[0], busy[1]}), 64'(0));

        for (int k = 0; k < 5; k++) load(k, rand_entry(1'b1));
        set_rsp(1);
        do_run("after_reset", 5, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/parser_rule_loader.md
# parser_rule_loader

Synthesizable rule-configuration sequencer for `Parser_Top`. A host preloads a table of {address, data} rule writes. On a start pulse the block replays the table through the parser's `i_rule_*` port, one write per entry, with optional per-entry read-back verification. It reports done and error status. It replaces the bench-side `force` configuration of layer type/key offsets, head/meta shifts and type rules with a path usable in silicon and in every bench.

## Interface
Parameters:
- `ENTRY_NUM`, 64: table depth (entries).
- `VERIFY`, 1: 1 enables read-back compare after each write; 0 skips it.
- `RD_TIMEOUT`, 15: maximum cycles to wait for `i_rule_rdata_valid` per read.
- `CNT_W`, `$clog2(ENTRY_NUM+1)`: entry count / index width.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_tbl_wren` in 1: table write strobe.
- `i_tbl_addr` in `CNT_W`: table entry index.
- `i_tbl_wdata` in 64: table entry. [63:32] = rule address, [31:0] = rule data.
- `i_entry_num` in `CNT_W`: number of valid entries. Sampled on start.
- `i_start` in 1: single-cycle start pulse.
- `o_busy` out 1: sequence in progress.
- `o_done` out 1: single-cycle completion pulse.
- `o_err` out 1: sticky error flag for the last run.
- `o_err_code` out 2: 01 = compare mismatch, 10 = read timeout.
- `o_err_idx` out `CNT_W`: index of the failing entry.
- `o_rule_wren`, `o_rule_rden` out 1: parser config strobes.
- `o_rule_addr` out 32: parser config address.
- `o_rule_wdata` out 32: parser config data.
- `i_rule_rdata_valid` in 1: parser read-data valid.
- `i_rule_rdata` in 32: parser read data.

## Operation
- Table entry rule-address bit 31 is a loader-only "no-verify" flag. It is always driven 0 on `o_rule_addr`. Bits [10:8] carry the parser class: 0 rules, 1 type data/mask, 2 type offset, 3 key offset, 4 head shift, 5 meta shift. Bits [15:12] select the parser layer.
- The table is a synchronous RAM with 1-cycle read latency. Host writes are accepted only while `o_busy`=0. Writes while busy are dropped.
- FSM states:
  - IDLE: waits for `i_start`.
  - FETCH: presents the table read address.
  - WRITE: `o_rule_wren`=1 for 1 cycle with the table address and data.
  - RDREQ: `o_rule_rden`=1 for 1 cycle at the same address.
  - RDWAIT: waits for `i_rule_rdata_valid`.
  - NEXT: increments the index.
  - DONE: pulses `o_done`, then returns to IDLE.
- Transitions:
  - IDLE→FETCH on `i_start` if count>0. IDLE→DONE if count=0.
  - FETCH→WRITE.
  - WRITE→RDREQ if `VERIFY`=1 and bit 31=0; otherwise WRITE→NEXT.
  - RDREQ→RDWAIT.
  - RDWAIT→NEXT on valid with data equal to the written data.
  - RDWAIT→DONE on valid with mismatch: set `o_err`, code 01, `o_err_idx`.
  - RDWAIT→DONE after `RD_TIMEOUT` cycles without valid: set `o_err`, code 10, `o_err_idx`.
  - NEXT→FETCH if index+1 < count; otherwise NEXT→DONE.
- The first error aborts the run. No further writes are issued after it.
- Count is clamped: if `i_entry_num` > `ENTRY_NUM`, `ENTRY_NUM` entries are used.
- `i_start` while busy is ignored.
- `i_start` clears `o_err`, `o_err_code` and `o_err_idx` when accepted.
- `i_rule_rdata_valid` outside RDWAIT is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, index 0. Table contents are undefined after reset.
- Reset mid-run: outputs return to 0 immediately (asynchronous). No further strobes are issued. The run is not resumed.
- Start to first `o_rule_wren`: `i_start` sampled at edge N, so FETCH in cycle N+1 and `o_rule_wren` in cycle N+2.
- Throughput:
  - Without verify: 3 cycles per entry (FETCH, WRITE, NEXT).
  - With verify: 5 + d cycles per entry, where d is the number of wait cycles before valid (d ≥ 0).
- `o_done` is high for exactly 1 cycle. On the same cycle `o_busy` is still 1; `o_busy` falls on the following cycle.
- Strobes are registered outputs. Address and data are stable for the whole strobe cycle and are held until the next strobe.
- Timeout counter: starts at 0 on entry to RDWAIT. Timeout fires when the counter reaches `RD_TIMEOUT` with no valid seen.

## Test plan
- **Reset:** assert `i_rst_n`=0 mid-run during a WRITE → all outputs 0 within the same cycle. After release, no strobes until a new `i_start`.
- **Layer-0 ethernet config, `VERIFY`=0, 9 entries:**
  - Stimulus: type offsets 12/13; key offsets 0..5 valid, 6..7 invalid; headShift 7; metaShift 6.
  - Required: exactly 9 `o_rule_wren` pulses, 3 cycles apart. `o_rule_addr`[31]=0 on all. `o_done` 27 cycles after the first FETCH. `o_err`=0.
- **`VERIFY`=1 with an echoing responder:**
  - Responder: returns the written data with d=2.
  - Required: 4 entries, each 7 cycles; `o_done` pulse; `o_err`=0.
  - An entry with bit 31 set produces no `o_rule_rden`.
- **Mismatch:** responder corrupts entry 2 (returns `32'h0000_0009` for written `32'h0000_0008`) → exactly 3 writes. `o_err`=1, `o_err_code`=01, `o_err_idx`=2, `o_done` pulses.
- **Timeout:** responder silent, `RD_TIMEOUT`=15 → `o_err_code`=10, `o_err_idx`=0, `o_done` 15 cycles after RDWAIT entry.
- **Boundaries:**
  - `i_entry_num`=0 → `o_done` one cycle after start, no strobes.
  - `i_entry_num`=`ENTRY_NUM`+5 → exactly `ENTRY_NUM` writes.
  - `i_start` and `i_tbl_wren` while busy → ignored; table contents unchanged.
